// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/local RAM arbiter: command encodings, FSM states,
// port ownership and the buffered RAM operation.
package spi_ram_pkg;

  localparam int unsigned OP_ADDR_W = 8;
  localparam int unsigned OP_DATA_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RDATA
  } arb_state_e;

  typedef enum logic {
    OWN_SPI,
    OWN_LOC
  } owner_e;

  typedef struct packed {
    logic                 we;
    logic [OP_ADDR_W-1:0] addr;
    logic [OP_DATA_W-1:0] data;
  } ram_op_t;

endpackage

// File: rtl/spi_ram_arbiter_capture.sv
// SPI command front end: rising-edge capture of rx words, address registers,
// a single-entry RAM op buffer and the sticky overflow flag.
module spi_cmd_capture
  import spi_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_DATA_W+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  input  logic                 pop,
  output ram_op_t              op,
  output logic                 op_valid,
  output logic                 spi_ovf
);

  logic                 rx_valid_q;
  logic [OP_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OP_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  ram_op_t              op_q, op_d;
  logic                 op_valid_q, op_valid_d;
  logic                 ovf_q, ovf_d;
  cmd_e                 cmd;
  logic [OP_DATA_W-1:0] payload;
  logic                 rise;
  logic                 full;

  assign cmd     = cmd_e'(spi_rx_data[OP_DATA_W+1 -: 2]);
  assign payload = spi_rx_data[OP_DATA_W-1:0];
  assign rise    = spi_rx_valid & ~rx_valid_q;
  // A pop frees the entry this cycle, so a same-cycle capture still fits.
  assign full    = op_valid_q & ~pop;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    op_d       = op_q;
    op_valid_d = op_valid_q & ~pop;
    ovf_d      = ovf_q;
    if (rise) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload;
        CMD_RD_ADDR: rd_addr_d = payload;
        CMD_WR_DATA: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            op_valid_d = 1'b1;
            op_d.we    = 1'b1;
            op_d.addr  = wr_addr_q;
            op_d.data  = payload;
          end
        end
        CMD_RD_DATA: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            op_valid_d = 1'b1;
            op_d.we    = 1'b0;
            op_d.addr  = rd_addr_q;
            op_d.data  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_valid_q <= spi_rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign op       = op_q;
  assign op_valid = op_valid_q;
  assign spi_ovf  = ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the SPI command path
// and a local requester; routes read data back to whichever side owns the op.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TX_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_tx_valid,
  output logic              spi_ovf,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              loc_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(TX_HOLD + 1);

  arb_state_e        state_q, state_d;
  owner_e            last_q, last_d;
  owner_e            owner_q, owner_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
  logic              loc_rvalid_q, loc_rvalid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;

  ram_op_t           spi_op;
  logic              spi_op_valid;
  logic              spi_pop;
  logic              win_valid;
  owner_e            win;

  spi_cmd_capture u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .pop          (spi_pop),
    .op           (spi_op),
    .op_valid     (spi_op_valid),
    .spi_ovf      (spi_ovf)
  );

  // On a tie the side that did not win last time takes the port.
  always_comb begin
    win_valid = 1'b0;
    win       = OWN_SPI;
    if (state_q == ARB_IDLE) begin
      if (spi_op_valid && loc_req) begin
        win_valid = 1'b1;
        win       = (last_q == OWN_LOC) ? OWN_SPI : OWN_LOC;
      end else if (spi_op_valid) begin
        win_valid = 1'b1;
        win       = OWN_SPI;
      end else if (loc_req) begin
        win_valid = 1'b1;
        win       = OWN_LOC;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (win_valid) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ram_we_q ? ARB_IDLE : ARB_RDATA;
      ARB_RDATA: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    last_d       = last_q;
    owner_d      = owner_q;
    ram_en_d     = 1'b0;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    loc_rdata_d  = loc_rdata_q;
    loc_rvalid_d = 1'b0;
    tx_data_d    = tx_data_q;
    tx_cnt_d     = (tx_cnt_q != '0) ? tx_cnt_q - 1'b1 : '0;
    if (win_valid) begin
      last_d   = win;
      owner_d  = win;
      ram_en_d = 1'b1;
      if (win == OWN_SPI) begin
        ram_we_d    = spi_op.we;
        ram_addr_d  = spi_op.addr;
        ram_wdata_d = spi_op.data;
      end else begin
        ram_we_d    = loc_we;
        ram_addr_d  = loc_addr;
        ram_wdata_d = loc_wdata;
      end
    end
    if (state_q == ARB_RDATA) begin
      if (owner_q == OWN_LOC) begin
        loc_rdata_d  = ram_rdata;
        loc_rvalid_d = 1'b1;
      end else begin
        tx_data_d = ram_rdata;
        tx_cnt_d  = CNT_W'(TX_HOLD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_q       <= OWN_LOC;
      owner_q      <= OWN_SPI;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
      tx_data_q    <= '0;
      tx_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      loc_rdata_q  <= loc_rdata_d;
      loc_rvalid_q <= loc_rvalid_d;
      tx_data_q    <= tx_data_d;
      tx_cnt_q     <= tx_cnt_d;
    end
  end

  assign spi_pop      = win_valid && (win == OWN_SPI);
  assign loc_gnt      = rst_n && win_valid && (win == OWN_LOC);
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign loc_rdata    = loc_rdata_q;
  assign loc_rvalid   = loc_rvalid_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_tx_valid = (tx_cnt_q != '0);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural single-port RAM
// (one-cycle read latency) on the RAM side.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_ovf;
  logic       loc_req;
  logic       loc_we;
  logic [7:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr_base;
  logic seen_tx;

  logic [7:0] mem [256] = '{default: 8'h00};

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .TX_HOLD(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .spi_ovf      (spi_ovf),
    .loc_req      (loc_req),
    .loc_we       (loc_we),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .loc_gnt      (loc_gnt),
    .loc_rdata    (loc_rdata),
    .loc_rvalid   (loc_rvalid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ram_en"},     ram_en,       1'b0);
    check({tag, ".ram_we"},     ram_we,       1'b0);
    check({tag, ".ram_addr"},   ram_addr,     8'h00);
    check({tag, ".ram_wdata"},  ram_wdata,    8'h00);
    check({tag, ".tx_valid"},   spi_tx_valid, 1'b0);
    check({tag, ".tx_data"},    spi_tx_data,  8'h00);
    check({tag, ".ovf"},        spi_ovf,      1'b0);
    check({tag, ".loc_gnt"},    loc_gnt,      1'b0);
    check({tag, ".loc_rvalid"}, loc_rvalid,   1'b0);
    check({tag, ".loc_rdata"},  loc_rdata,    8'h00);
  endtask

  initial begin
    rst_n        = 1'b0;
    spi_rx_data  = '0;
    spi_rx_valid = 1'b0;
    loc_req      = 1'b0;
    loc_we       = 1'b0;
    loc_addr     = '0;
    loc_wdata    = '0;
    ram_rdata    = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // 1: address word held high 5 cycles, then one write of 0xA5 to 0x3C
    spi_rx_data = {2'b00, 8'h3C}; spi_rx_valid = 1'b1;
    repeat (5) step();
    spi_rx_valid = 1'b0;
    step();
    wr_base = wr_cnt;
    spi_rx_data = {2'b01, 8'hA5}; spi_rx_valid = 1'b1;          // T
    step();                                                        // T+1
    check("t1.en_t1", ram_en, 1'b0);
    step();                                                        // T+2
    spi_rx_valid = 1'b0;
    check("t1.en", ram_en, 1'b1);
    check("t1.we", ram_we, 1'b1);
    check("t1.addr", ram_addr, 8'h3C);
    check("t1.wdata", ram_wdata, 8'hA5);
    step();                                                        // T+3
    check("t1.en_off", ram_en, 1'b0);
    check("t1.addr_hold", ram_addr, 8'h3C);
    repeat (3) step();
    check("t1.one_write", wr_cnt - wr_base, 1);
    check("t1.ovf", spi_ovf, 1'b0);

    // 2: SPI read of 0x3C, tx_valid held T+4..T+13
    spi_rx_data = {2'b10, 8'h3C}; spi_rx_valid = 1'b1;
    step(); spi_rx_valid = 1'b0; step();
    spi_rx_data = {2'b11, 8'h00}; spi_rx_valid = 1'b1;          // T
    step(); spi_rx_valid = 1'b0;                                  // T+1
    step();                                                        // T+2
    check("t2.en", ram_en, 1'b1);
    check("t2.we", ram_we, 1'b0);
    check("t2.addr", ram_addr, 8'h3C);
    step();                                                        // T+3
    check("t2.txv_t3", spi_tx_valid, 1'b0);
    step();                                                        // T+4
    check("t2.txv_t4", spi_tx_valid, 1'b1);
    check("t2.txd", spi_tx_data, 8'hA5);
    repeat (9) step();                                             // T+13
    check("t2.txv_t13", spi_tx_valid, 1'b1);
    step();                                                        // T+14
    check("t2.txv_t14", spi_tx_valid, 1'b0);
    check("t2.txd_hold", spi_tx_data, 8'hA5);

    // 3: tie after reset -> SPI first, LOC second
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    spi_rx_data = {2'b00, 8'h20}; spi_rx_valid = 1'b1;
    step(); spi_rx_valid = 1'b0; step();
    spi_rx_data = {2'b01, 8'h77}; spi_rx_valid = 1'b1;          // T
    step();                                                        // T+1
    spi_rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h10; loc_wdata = 8'h55;
    #1;
    check("t3.gnt_t1", loc_gnt, 1'b0);
    step();                                                        // T+2
    check("t3.spi_en", ram_en, 1'b1);
    check("t3.spi_addr", ram_addr, 8'h20);
    check("t3.spi_wdata", ram_wdata, 8'h77);
    check("t3.gnt_t2", loc_gnt, 1'b0);
    step();                                                        // T+3
    check("t3.gnt_t3", loc_gnt, 1'b1);
    check("t3.en_t3", ram_en, 1'b0);
    step();                                                        // T+4
    loc_req = 1'b0;
    check("t3.loc_en", ram_en, 1'b1);
    check("t3.loc_we", ram_we, 1'b1);
    check("t3.loc_addr", ram_addr, 8'h10);
    check("t3.loc_wdata", ram_wdata, 8'h55);
    step();                                                        // T+5 idle

    // 4: local read of 0x10
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;              // t
    #1;
    check("t4.gnt", loc_gnt, 1'b1);
    step();                                                        // t+1
    loc_req = 1'b0;
    check("t4.en", ram_en, 1'b1);
    check("t4.we", ram_we, 1'b0);
    check("t4.addr", ram_addr, 8'h10);
    step();                                                        // t+2
    check("t4.rv_t2", loc_rvalid, 1'b0);
    step();                                                        // t+3
    check("t4.rv_t3", loc_rvalid, 1'b1);
    check("t4.rdata", loc_rdata, 8'h55);
    step();                                                        // t+4
    check("t4.rv_t4", loc_rvalid, 1'b0);
    step();

    // 5: overflow while LOC holds the port; address cmd still lands
    spi_rx_data = {2'b11, 8'h00}; spi_rx_valid = 1'b1;          // a
    step();                                                        // a+1
    spi_rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;
    #1;
    check("t5.gnt_a1", loc_gnt, 1'b0);
    step();                                                        // a+2
    spi_rx_data = {2'b01, 8'hB1}; spi_rx_valid = 1'b1;
    step();                                                        // a+3
    spi_rx_valid = 1'b0;
    step();                                                        // a+4
    check("t5.ovf_pre", spi_ovf, 1'b0);
    spi_rx_data = {2'b01, 8'hB2}; spi_rx_valid = 1'b1;
    #1;
    check("t5.gnt_a4", loc_gnt, 1'b1);
    step();                                                        // a+5
    spi_rx_valid = 1'b0; loc_req = 1'b0;
    check("t5.ovf", spi_ovf, 1'b1);
    step();                                                        // a+6
    spi_rx_data = {2'b00, 8'h99}; spi_rx_valid = 1'b1;
    step();                                                        // a+7
    spi_rx_valid = 1'b0;
    check("t5.loc_rv", loc_rvalid, 1'b1);
    check("t5.loc_rd", loc_rdata, 8'h55);
    step();                                                        // a+8
    check("t5.en", ram_en, 1'b1);
    check("t5.addr", ram_addr, 8'h20);
    check("t5.wdata", ram_wdata, 8'hB1);
    step();                                                        // a+9
    spi_rx_data = {2'b01, 8'hC3}; spi_rx_valid = 1'b1;
    step(); spi_rx_valid = 1'b0;                                  // a+10
    step();                                                        // a+11
    check("t5.new_en", ram_en, 1'b1);
    check("t5.new_addr", ram_addr, 8'h99);
    check("t5.new_wdata", ram_wdata, 8'hC3);
    check("t5.ovf_sticky", spi_ovf, 1'b1);
    repeat (2) step();

    // 6: asynchronous reset during ARB_RDATA of an SPI read
    spi_rx_data = {2'b10, 8'h3C}; spi_rx_valid = 1'b1;
    step(); spi_rx_valid = 1'b0; step();
    spi_rx_data = {2'b11, 8'h00}; spi_rx_valid = 1'b1;          // T
    step(); spi_rx_valid = 1'b0;                                  // T+1
    step();                                                        // T+2
    check("t6.en", ram_en, 1'b1);
    step();                                                        // T+3
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6");
    step(); step();
    rst_n = 1'b1;
    seen_tx = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_tx = seen_tx | spi_tx_valid;
    end
    check("t6.no_tx", seen_tx, 1'b0);
    check("t6.ovf_clr", spi_ovf, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave, the single-port RAM and a second local requester (on-chip host/DMA).
- Decodes SPI 10-bit command words into RAM operations and holds the address registers.
- Arbitrates the single RAM port round-robin between the SPI path and the local port.
- Returns read data to the SPI slave (tx_data/tx_valid) or to the local port.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width; SPI word is DATA_W+2 bits.
- TX_HOLD, 10, cycles spi_tx_valid is held high so the slave can shift out all bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_rx_data  in  10  command word from the SPI slave: [9:8]=cmd, [7:0]=payload.
- spi_rx_valid  in  1  level from the SPI slave; may stay high for many cycles.
- spi_tx_data  out  8  read data to the SPI slave.
- spi_tx_valid  out  1  read data valid, held for TX_HOLD cycles.
- spi_ovf  out  1  sticky: an SPI op was dropped because the buffer was full.
- loc_req  in  1  local request; loc_we/loc_addr/loc_wdata are stable while high.
- loc_we  in  1  1=write, 0=read.
- loc_addr  in  8  local address.
- loc_wdata  in  8  local write data.
- loc_gnt  out  1  1-cycle pulse: request accepted.
- loc_rdata  out  8  local read data.
- loc_rvalid  out  1  1-cycle pulse with loc_rdata.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset (async, rst_n=0): every output is 0; wr_addr=rd_addr=0; SPI buffer empty; last_grant=LOC (so SPI wins the first tie); FSM=ARB_IDLE; tx hold counter=0.
- SPI capture: a word is captured only on a spi_rx_valid rising edge (registered previous value). A continuously high spi_rx_valid is one word.
- cmd 00: wr_addr<=payload. No RAM access. Processed even when the buffer is full.
- cmd 10: rd_addr<=payload. Same rules as cmd 00.
- cmd 01: buffer<={we=1, addr=wr_addr, data=payload}.
- cmd 11: buffer<={we=0, addr=rd_addr}; payload is ignored.
- The address is snapshotted at capture. A later address command does not alter an op already buffered.
- Buffer full on a cmd 01/11 capture: the word is dropped, spi_ovf<=1 (sticky until reset), and the buffered op is unchanged.
- Buffer clears in the cycle its op is granted, so a new capture can arrive in the same cycle.
- FSM states:
  - ARB_IDLE: if the SPI buffer is valid and/or loc_req is high, pick a winner. With both pending, the winner is the side that is not last_grant; otherwise the sole requester wins. Update last_grant. If LOC wins, pulse loc_gnt in this cycle. Register ram_en=1, ram_we, ram_addr, ram_wdata for the next cycle. Go to ARB_ISSUE.
  - ARB_ISSUE: ram_en is high for exactly this cycle. On a write, go to ARB_IDLE. On a read, go to ARB_RDATA.
  - ARB_RDATA: sample ram_rdata.
    - Owner LOC: loc_rdata<=ram_rdata, loc_rvalid pulse next cycle.
    - Owner SPI: spi_tx_data<=ram_rdata, spi_tx_valid=1 from the next cycle for TX_HOLD cycles.
    - Go to ARB_IDLE.
- ram_en is 0 in ARB_IDLE and ARB_RDATA. ram_addr and ram_wdata hold their last values when ram_en=0.
- Throughput: write takes 2 cycles per op; read takes 3 cycles per op.
- SPI read latency: capture edge at cycle T → buffer valid T+1 → ram_en T+2 → RDATA T+3 → spi_tx_valid high T+4 … T+3+TX_HOLD.
- A new SPI read completing while spi_tx_valid is held reloads spi_tx_data and restarts the counter.
- loc_req is never granted twice for one request, because loc_gnt forces the requester to drop or change the request next cycle.
- Reset mid-operation aborts everything with no partial RAM write beyond the cycle already issued. spi_ovf clears.

Decomposition:
- Package spi_ram_pkg:
  - cmd_e: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - arb_state_e: ARB_IDLE, ARB_ISSUE, ARB_RDATA.
  - owner_e: OWN_SPI, OWN_LOC.
  - ram_op_t: struct {we, addr, data}.
- Sub-module spi_cmd_capture: edge detect, decode, address registers, single-entry buffer and spi_ovf. Outputs ram_op_t plus valid; input pop.

Test Plan:
1. SPI 00 with 0x3C (rx_valid held 5 cycles), then 01 with 0xA5 → exactly one RAM write: ram_en=1, ram_we=1, addr=0x3C, wdata=0xA5; spi_ovf=0.
2. SPI 10 with 0x3C, then 11; RAM returns 0xA5 → ram_en with we=0 at T+2; spi_tx_data=0xA5 and spi_tx_valid high T+4 through T+13 (TX_HOLD=10).
3. loc_req write 0x10←0x55 and a buffered SPI write to 0x20 present in the same cycle after reset → SPI is granted first, LOC second (loc_gnt 1 pulse); two back-to-back writes 2 cycles apart.
4. Local read of 0x10 with RAM returning 0x55 → loc_gnt at cycle t, ram_en at t+1, loc_rvalid pulse with loc_rdata=0x55 at t+3.
5. Hold loc_req continuously and issue two SPI 01 ops before the first is served → second dropped, spi_ovf=1. An address command during the full buffer still updates wr_addr.
6. Drop rst_n asynchronously during ARB_RDATA of an SPI read → all outputs 0 immediately; spi_tx_valid never asserts; spi_ovf cleared.
